// File: rtl/ss_stack.sv
// ForthSuper data/return stack: registered tos/s0 over a sync-read RAM body; SS_CHECK_EN adds ovf/udf guarding.
// LOAD/PUSH take effect next cycle with rdy held high; POP refills s0 and PICK loads tos two cycles after acceptance.
// rdy drops for one cycle during POP/PICK; en while rdy=0 is ignored, so the master holds its op until rdy.
module ss_stack #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    localparam int SSZ  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     op,
    input  logic [DSZ-1:0] vi,
    output logic           rdy,
    output logic [SSZ-1:0] sp,
    output logic [SSZ-1:0] sp_1,
    output logic [DSZ-1:0] s0,
    output logic [DSZ-1:0] tos,
    output logic           ovf,
    output logic           udf
);

    typedef enum logic [1:0] {
        SS_LOAD = 2'd0,
        SS_PUSH = 2'd1,
        SS_POP  = 2'd2,
        SS_PICK = 2'd3
    } sop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PICK = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SSZ-1:0]   sp_q, sp_d;
    logic [SSZ-1:0]   rd_addr_q, rd_addr_d;
    logic [DSZ-1:0]   tos_q, tos_d;
    logic [DSZ-1:0]   s0_q, s0_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en;
    logic [DSZ-1:0]   rd_dat;
    logic             push_bad, pop_bad, pick_bad;
    sop_e             op_e;

    logic [DSZ-1:0]   mem [DEPTH];

    assign op_e = sop_e'(op);

`ifdef SS_CHECK_EN
    assign push_bad = (sp_q == SSZ'(DEPTH - 1));
    assign pop_bad  = (sp_q == '0);
    assign pick_bad = (vi[SSZ-1:0] >= sp_q);
`else
    assign push_bad = 1'b0;
    assign pop_bad  = 1'b0;
    assign pick_bad = 1'b0;
`endif

    // Write lands at the accept edge; a POP right after reads sp-2, never the slot just written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sp_q] <= tos_q;
        end
    end

    assign rd_dat = mem[rd_addr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sp_q      <= '0;
            rd_addr_q <= '0;
            tos_q     <= '1;
            s0_q      <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            rd_addr_q <= rd_addr_d;
            tos_q     <= tos_d;
            s0_q      <= s0_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        rd_addr_d = rd_addr_q;
        tos_d     = tos_q;
        s0_d      = s0_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        wr_en     = 1'b0;
        rdy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    case (op_e)
                        SS_LOAD: tos_d = vi;
                        SS_PUSH: begin
                            if (push_bad) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_en = 1'b1;
                                s0_d  = tos_q;
                                tos_d = vi;
                                sp_d  = sp_q + SSZ'(1);
                            end
                        end
                        SS_POP: begin
                            if (pop_bad) begin
                                udf_d = 1'b1;
                            end else begin
                                tos_d     = s0_q;
                                sp_d      = sp_q - SSZ'(1);
                                rd_addr_d = sp_q - SSZ'(2);
                                state_d   = ST_FILL;
                            end
                        end
                        SS_PICK: begin
                            if (pick_bad) begin
                                udf_d = 1'b1;
                            end else begin
                                rd_addr_d = sp_q - SSZ'(1) - vi[SSZ-1:0];
                                state_d   = ST_PICK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FILL: begin
                s0_d    = rd_dat;
                state_d = ST_IDLE;
            end
            ST_PICK: begin
                tos_d   = rd_dat;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sp   = sp_q;
    assign sp_1 = sp_q - SSZ'(1);
    assign s0   = s0_q;
    assign tos  = tos_q;
    assign ovf  = ovf_q;
    assign udf  = udf_q;

endmodule

// File: tb/tb_ss_stack.sv
// Scoreboard bench for ss_stack: a reference stack model queues expected end states, compared when rdy returns.
module tb_ss_stack;

    localparam int DEPTH = 64;
    localparam int DSZ   = 32;
    localparam int SSZ   = 6;
`ifdef SS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_PICK = 2'd3;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [1:0]     op;
    logic [DSZ-1:0] vi;
    logic           rdy;
    logic [SSZ-1:0] sp, sp_1;
    logic [DSZ-1:0] s0, tos;
    logic           ovf, udf;

    ss_stack #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .vi(vi),
        .rdy(rdy), .sp(sp), .sp_1(sp_1), .s0(s0), .tos(tos),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DSZ-1:0] tos;
        logic [DSZ-1:0] s0;
        logic           s0_vld;
        logic [SSZ-1:0] sp;
        logic           ovf;
        logic           udf;
        logic           busy;
    } exp_t;

    exp_t exp_q[$];

    logic [DSZ-1:0] mem_m [DEPTH];
    logic           vld_m [DEPTH];
    logic [DSZ-1:0] tos_m, s0_m;
    logic           s0v_m, ovf_m, udf_m;
    logic [SSZ-1:0] sp_m;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [DSZ-1:0] act, input logic [DSZ-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        tos_m = '1;
        s0_m  = '0;
        s0v_m = 1'b1;
        sp_m  = '0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [1:0] o, input logic [DSZ-1:0] v, output exp_t e);
        logic [SSZ-1:0] n;
        e.busy = 1'b0;
        case (o)
            OP_LOAD: tos_m = v;
            OP_PUSH: begin
                if (CHK && sp_m == SSZ'(DEPTH - 1)) begin
                    ovf_m = 1'b1;
                end else begin
                    mem_m[sp_m] = tos_m;
                    vld_m[sp_m] = 1'b1;
                    s0_m  = tos_m;
                    s0v_m = 1'b1;
                    tos_m = v;
                    sp_m  = sp_m + 1'b1;
                end
            end
            OP_POP: begin
                if (CHK && sp_m == '0) begin
                    udf_m = 1'b1;
                end else begin
                    tos_m  = s0_m;
                    sp_m   = sp_m - 1'b1;
                    s0_m   = mem_m[SSZ'(sp_m - 1'b1)];
                    s0v_m  = vld_m[SSZ'(sp_m - 1'b1)];
                    e.busy = 1'b1;
                end
            end
            default: begin
                n = v[SSZ-1:0];
                if (CHK && n >= sp_m) begin
                    udf_m = 1'b1;
                end else begin
                    tos_m  = mem_m[SSZ'(sp_m - 1'b1 - n)];
                    e.busy = 1'b1;
                end
            end
        endcase
        e.tos    = tos_m;
        e.s0     = s0_m;
        e.s0_vld = s0v_m;
        e.sp     = sp_m;
        e.ovf    = ovf_m;
        e.udf    = udf_m;
        exp_q.push_back(e);
    endtask

    task automatic wait_rdy(input string tag);
        int guard = 0;
        while (rdy !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (rdy !== 1'b1) check({tag, "_rdy_timeout"}, {31'd0, rdy}, 1);
    endtask

    task automatic compare_exp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_tos"}, tos, e.tos);
        if (e.s0_vld) check({tag, "_s0"}, s0, e.s0);
        check({tag, "_sp"}, {26'd0, sp}, {26'd0, e.sp});
        check({tag, "_sp_1"}, {26'd0, sp_1}, {26'd0, SSZ'(e.sp - 1'b1)});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
        check({tag, "_udf"}, {31'd0, udf}, {31'd0, e.udf});
    endtask

    // Called at a negedge; returns at the negedge where the op has fully completed.
    task automatic issue(input string tag, input logic [1:0] o, input logic [DSZ-1:0] v);
        exp_t e;
        wait_rdy(tag);
        model_apply(o, v, e);
        en = 1'b1;
        op = o;
        vi = v;
        @(negedge clk);
        en = 1'b0;
        check({tag, "_rdy_mid"}, {31'd0, rdy}, {31'd0, ~e.busy});
        check({tag, "_sp_mid"}, {26'd0, sp}, {26'd0, e.sp});
        if (o == OP_POP && e.busy) check({tag, "_tos_mid"}, tos, e.tos);
        wait_rdy(tag);
        compare_exp(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rdy"}, {31'd0, rdy}, 1);
        check({tag, "_sp"}, {26'd0, sp}, 0);
        check({tag, "_tos"}, tos, 32'hFFFF_FFFF);
        check({tag, "_s0"}, s0, 0);
        check({tag, "_ovf"}, {31'd0, ovf}, 0);
        check({tag, "_udf"}, {31'd0, udf}, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        op  = 2'd0;
        vi  = '0;
        for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("por");

        issue("push11", OP_PUSH, 32'h11);
        issue("push22", OP_PUSH, 32'h22);
        issue("push33", OP_PUSH, 32'h33);
        issue("pop1", OP_POP, 32'h0);
        issue("repush33", OP_PUSH, 32'h33);

        // en held high with POP: second POP must wait out the FILL cycle.
        begin
            exp_t e1, e2;
            model_apply(OP_POP, 0, e1);
            model_apply(OP_POP, 0, e2);
            en = 1'b1;
            op = OP_POP;
            vi = '0;
            @(negedge clk);
            check("held_rdy_fill", {31'd0, rdy}, 0);
            check("held_tos_fill", tos, 32'h22);
            check("held_sp_fill", {26'd0, sp}, 2);
            @(negedge clk);
            check("held_rdy_idle", {31'd0, rdy}, 1);
            compare_exp("held_pop_a");
            @(negedge clk);
            en = 1'b0;
            check("held_rdy_fill2", {31'd0, rdy}, 0);
            wait_rdy("held_pop_b");
            compare_exp("held_pop_b");
            check("held_tos_first", tos, 32'h11);
        end

        pulse_reset();
        issue("pushA", OP_PUSH, 32'hA);
        issue("pushB", OP_PUSH, 32'hB);
        issue("pushC", OP_PUSH, 32'hC);
        issue("pushD", OP_PUSH, 32'hD);
        issue("load2", OP_LOAD, 32'h2);
        issue("pick2", OP_PICK, 32'h2);
        check("pick2_tos_A", tos, 32'hA);
        issue("pick0", OP_PICK, 32'h0);
        issue("pick_hibits", OP_PICK, 32'h0000_0041);
        issue("push55", OP_PUSH, 32'h55);
        issue("pop_after_push", OP_POP, 32'h0);

        // Reset landing while a PICK read is in flight.
        en = 1'b1;
        op = OP_PICK;
        vi = 32'h1;
        @(negedge clk);
        en = 1'b0;
        check("midpick_busy", {31'd0, rdy}, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_state("midpick_rst");

`ifdef SS_CHECK_EN
        issue("udf_pop", OP_POP, 32'h0);
        check("udf_flag", {31'd0, udf}, 1);
        pulse_reset();
        for (int i = 0; i < DEPTH - 1; i++) issue("fill", OP_PUSH, 32'h100 + i);
        issue("ovf_push", OP_PUSH, 32'hDEAD);
        check("ovf_flag", {31'd0, ovf}, 1);
        check("ovf_tos_kept", tos, 32'h100 + DEPTH - 2);
        pulse_reset();
        issue("one_push", OP_PUSH, 32'h77);
        issue("pick_oob", OP_PICK, 32'h1);
`else
        issue("pop_wrap", OP_POP, 32'h0);
        check("wrap_sp", {26'd0, sp}, DEPTH - 1);
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) issue("fill", OP_PUSH, 32'h100 + i);
        check("wrap_sp_zero", {26'd0, sp}, 0);
        issue("pick_after_wrap", OP_PICK, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ss_stack.md
Name: ss_stack

Overview:
- Data/return stack engine for ForthSuper; the slave side of the stack-op interface.
- Consumes op/vi from the core's stack master.
- Produces the cached top-of-stack (tos), the cached next-of-stack (s0), and the stack pointers.
- Body lives in a synchronous-read block RAM; tos and s0 are registers, so PUSH, LOAD and the tos effect of POP are visible one cycle after acceptance.

Parameters:
- DEPTH, 64, number of RAM entries (power of two); sp wraps modulo DEPTH.
- DSZ, 32, data width of tos, s0, vi and RAM words.
- SSZ, $clog2(DEPTH), localparam, pointer width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  op strobe; op is accepted when en && rdy.
- op  in  2  sop_e: SS_LOAD=0, SS_PUSH=1, SS_POP=2, SS_PICK=3.
- vi  in  DSZ  operand: LOAD/PUSH value, or PICK index n.
- rdy  out  1  engine idle, can accept an op this cycle.
- sp  out  SSZ  count/pointer of RAM-resident entries (next write slot).
- sp_1  out  SSZ  (sp + DEPTH-1) mod DEPTH, combinational from sp.
- s0  out  DSZ  cached copy of RAM[sp_1].
- tos  out  DSZ  top-of-stack register.
- ovf  out  1  sticky overflow flag (see Optional Feature).
- udf  out  1  sticky underflow flag (see Optional Feature).

Behaviour:
- Reset (async, any state): state=IDLE, sp=0, tos=all-ones, s0=0, rdy=1, ovf=0, udf=0. RAM contents are not cleared. Any in-flight FILL or PICK is aborted.
- FSM states: IDLE, FILL, PICK. rdy=1 only in IDLE. en while rdy=0 is ignored; the master must hold its op until rdy.
- SS_LOAD accepted at edge T:
  - tos<=vi at T+1; sp and s0 unchanged.
  - Stays IDLE; back-to-back allowed.
- SS_PUSH accepted at T:
  - RAM[sp]<=tos, s0<=tos, tos<=vi, sp<=sp+1 (mod DEPTH), all at T+1.
  - Stays IDLE; back-to-back pushes sustain 1 per cycle.
- SS_POP accepted at T:
  - At T+1: tos<=s0, sp<=sp-1, RAM read address (old sp-2) registered, state->FILL.
  - At T+2: s0<=RAM data (= RAM[new sp_1]), state->IDLE.
  - Latency 2 cycles; rdy low for 1 cycle.
- SS_PICK n accepted at T:
  - Read address a=(sp-1-n[SSZ-1:0]) mod DEPTH registered; state->PICK.
  - At T+2: tos<=RAM[a], state->IDLE. sp and s0 unchanged.
  - n=0 yields s0's value (DUP-of-second semantics). Upper bits of vi above SSZ are ignored.
- PUSH followed immediately by POP: the POP returns the pushed tos and s0 refills from RAM correctly; no write-read hazard (write at T+1, read at T+1 uses the new address, so the RAM must provide write-first or an address-inequality guarantee, which holds since the read is sp-2).
- Arithmetic is all modulo DEPTH on pointers; no saturation unless the feature is enabled.

Optional Feature:
- Macro SS_CHECK_EN.
- Defined:
  - PUSH with sp==DEPTH-1 is dropped (no state change) and sets ovf.
  - POP with sp==0 is dropped and sets udf.
  - PICK with n>=sp is dropped and sets udf.
  - Dropped ops keep rdy=1 and state IDLE.
  - Flags are sticky until rst.
- Undefined: ovf=udf=0 constant; pointers wrap silently modulo DEPTH; all ops always execute.

Test Plan:
- Reset: assert rst mid-PICK -> next sample rdy=1, sp=0, tos=0xFFFFFFFF, s0=0, ovf=udf=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles -> tos=0x33, s0=0x22, sp=3, rdy stays 1 throughout.
- From previous state, POP -> T+1 tos=0x22, sp=2, rdy=0; T+2 s0=0x11, rdy=1.
- Push 0xA,0xB,0xC,0xD then LOAD 2 followed by PICK with vi=2 -> after 2 cycles tos=0xA, sp=4, s0=0xC.
- en held high with POP during FILL -> second POP accepted only once rdy=1; after two POPs from sp=3 the result is sp=1, tos equal to the first pushed value.
- SS_CHECK_EN: 63 pushes at DEPTH=64 then one more -> ovf=1, sp=63, tos unchanged. From reset, a POP -> udf=1, sp=0.
